// File: rtl/hacd_decompressor_mc.sv
// Zero/raw/replicate chunk decompressor: reads one metadata line plus payload
// from the read FIFO and expands NUM_CHUNKS x LINES_PER_CHUNK lines into the write FIFO.
module hacd_decompressor_mc #(
    parameter int DATA_WIDTH      = 512,
    parameter int NUM_CHUNKS      = 4,
    parameter int LINES_PER_CHUNK = 16,
    parameter int CSZ_W           = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  decomp_start,
    input  logic [CSZ_W-1:0]      comp_size,
    input  logic                  rdfifo_empty,
    output logic                  rd_req,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [1:0]            rd_rresp,
    input  logic                  wrfifo_full,
    output logic                  wr_req,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  decomp_busy,
    output logic                  decomp_done,
    output logic                  decomp_err,
    output logic [1:0]            err_code
);

    localparam int LCW = $clog2(LINES_PER_CHUNK) + 1;
    localparam int CIW = $clog2(NUM_CHUNKS) + 1;
    localparam int MW  = 2 * NUM_CHUNKS;

    localparam logic [LCW-1:0] LINE_LAST = LCW'(LINES_PER_CHUNK - 1);
    localparam logic [CIW-1:0] CHUNK_END = CIW'(NUM_CHUNKS);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_META     = 4'd1;
    localparam logic [3:0] S_SEL      = 4'd2;
    localparam logic [3:0] S_ZERO     = 4'd3;
    localparam logic [3:0] S_RAW      = 4'd4;
    localparam logic [3:0] S_REP_LD   = 4'd5;
    localparam logic [3:0] S_REP_FILL = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
    localparam logic [3:0] S_ERROR    = 4'd8;

    logic [3:0]            r_state;
    logic                  r_outstanding;
    logic                  r_rd_req;
    logic                  r_wr_req;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_rep_line;
    logic [MW-1:0]         r_modes;
    logic [CIW-1:0]        r_chunk;
    logic [LCW-1:0]        r_line;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [1:0]            r_err_code;

    logic [31:0] w_raw_cnt;
    logic [31:0] w_rep_cnt;
    logic [31:0] w_exp_size;
    logic        w_rsvd;
    logic [1:0]  w_cur_mode;
    logic        w_rd_ok;
    logic        w_line_last;

    // Metadata decode: expected compressed length counts the metadata line itself.
    always_comb begin
        w_raw_cnt = '0;
        w_rep_cnt = '0;
        w_rsvd    = 1'b0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            case (rd_data[2*i +: 2])
                2'b00:   w_raw_cnt = w_raw_cnt + 32'd1;
                2'b10:   w_rep_cnt = w_rep_cnt + 32'd1;
                2'b11:   w_rsvd    = 1'b1;
                default: ;
            endcase
        end
        w_exp_size = 32'd1 + w_raw_cnt * 32'(LINES_PER_CHUNK) + w_rep_cnt;
    end

    always_comb begin
        w_cur_mode = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (r_chunk == CIW'(i)) w_cur_mode = r_modes[2*i +: 2];
        end
    end

    // Handshake: rd_req is a one-cycle pop with at most one read outstanding until
    // rd_valid returns; wr_req is a one-cycle push issued only after a cycle with
    // wrfifo_full low, except a returning raw line, which the almost-full slack absorbs.
    assign w_rd_ok     = !r_outstanding && !rdfifo_empty;
    assign w_line_last = (r_line == LINE_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_outstanding <= 1'b0;
            r_rd_req      <= 1'b0;
            r_wr_req      <= 1'b0;
            r_wr_data     <= '0;
            r_rep_line    <= '0;
            r_modes       <= '0;
            r_chunk       <= '0;
            r_line        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= 2'd0;
        end else begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            if (rd_valid) r_outstanding <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (decomp_start && !rdfifo_empty) begin
                        r_state <= S_META;
                        r_busy  <= 1'b1;
                        r_chunk <= '0;
                        r_line  <= '0;
                    end
                end
                S_META: begin
                    if (rd_valid) begin
                        if (rd_rresp != 2'd0) begin
                            r_state <= S_ERROR; r_err <= 1'b1; r_err_code <= 2'd1;
                        end else if (w_rsvd) begin
                            r_state <= S_ERROR; r_err <= 1'b1; r_err_code <= 2'd3;
                        end else if (w_exp_size != 32'(comp_size)) begin
                            r_state <= S_ERROR; r_err <= 1'b1; r_err_code <= 2'd2;
                        end else begin
                            r_modes <= rd_data[MW-1:0];
                            r_chunk <= '0;
                            r_state <= S_SEL;
                        end
                    end else if (w_rd_ok) begin
                        r_rd_req      <= 1'b1;
                        r_outstanding <= 1'b1;
                    end
                end
                S_SEL: begin
                    if (r_chunk == CHUNK_END) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_line <= '0;
                        case (w_cur_mode)
                            2'b00:   r_state <= S_RAW;
                            2'b01:   r_state <= S_ZERO;
                            default: r_state <= S_REP_LD;
                        endcase
                    end
                end
                S_ZERO, S_REP_FILL: begin
                    if (!wrfifo_full) begin
                        r_wr_req  <= 1'b1;
                        r_wr_data <= (r_state == S_ZERO) ? '0 : r_rep_line;
                        r_line    <= r_line + 1'b1;
                        if (w_line_last) begin
                            r_chunk <= r_chunk + 1'b1;
                            r_state <= S_SEL;
                        end
                    end
                end
                S_RAW: begin
                    if (rd_valid) begin
                        if (rd_rresp != 2'd0) begin
                            r_state <= S_ERROR; r_err <= 1'b1; r_err_code <= 2'd1;
                        end else begin
                            r_wr_req  <= 1'b1;
                            r_wr_data <= rd_data;
                            r_line    <= r_line + 1'b1;
                            if (w_line_last) begin
                                r_chunk <= r_chunk + 1'b1;
                                r_state <= S_SEL;
                            end
                        end
                    end else if (w_rd_ok && !wrfifo_full) begin
                        r_rd_req      <= 1'b1;
                        r_outstanding <= 1'b1;
                    end
                end
                S_REP_LD: begin
                    if (rd_valid) begin
                        if (rd_rresp != 2'd0) begin
                            r_state <= S_ERROR; r_err <= 1'b1; r_err_code <= 2'd1;
                        end else begin
                            r_rep_line <= rd_data;
                            r_state    <= S_REP_FILL;
                        end
                    end else if (w_rd_ok) begin
                        r_rd_req      <= 1'b1;
                        r_outstanding <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!decomp_start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_ERROR: begin
                    if (!decomp_start) begin
                        r_state    <= S_IDLE;
                        r_err      <= 1'b0;
                        r_err_code <= 2'd0;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_req      = r_rd_req;
    assign wr_req      = r_wr_req;
    assign wr_data     = r_wr_data;
    assign decomp_busy = r_busy;
    assign decomp_done = r_done;
    assign decomp_err  = r_err;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_hacd_decompressor_mc.sv
// Directed bench for hacd_decompressor_mc: read-FIFO responder with random latency,
// write scoreboard fed from an expected queue, and status checks per operation.
module tb_hacd_decompressor_mc;

    localparam int DW  = 512;
    localparam int CSW = 14;

    logic           clk_i;
    logic           rst_i;
    logic           decomp_start;
    logic [CSW-1:0] comp_size;
    logic           rdfifo_empty;
    logic           rd_req;
    logic           rd_valid;
    logic [DW-1:0]  rd_data;
    logic [1:0]     rd_rresp;
    logic           wrfifo_full;
    logic           wr_req;
    logic [DW-1:0]  wr_data;
    logic           decomp_busy;
    logic           decomp_done;
    logic           decomp_err;
    logic [1:0]     err_code;

    hacd_decompressor_mc #(
        .DATA_WIDTH(DW), .NUM_CHUNKS(4), .LINES_PER_CHUNK(16), .CSZ_W(CSW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .decomp_start(decomp_start), .comp_size(comp_size),
        .rdfifo_empty(rdfifo_empty), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_rresp(rd_rresp), .wrfifo_full(wrfifo_full), .wr_req(wr_req), .wr_data(wr_data),
        .decomp_busy(decomp_busy), .decomp_done(decomp_done), .decomp_err(decomp_err),
        .err_code(err_code)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [DW-1:0] rd_q[$];
    logic [1:0]    rs_q[$];
    logic [DW-1:0] exp_q[$];

    int n_total;
    int n_bad;
    int rd_cnt;
    int wr_cnt;
    bit pend;
    int pend_dly;
    bit bp_check;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        logic [31:0] w;
        w = 32'(k) ^ 32'hA5A5_0000;
        return {16{w}};
    endfunction

    // One cycle: score writes, answer reads, refresh FIFO-empty.
    task automatic tick();
        @(negedge clk_i);
        if (wr_req) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("wr_unexpected_q_depth", DW'(exp_q.size()), DW'(1));
            else                   chk("wr_data", wr_data, exp_q.pop_front());
        end
        if (bp_check && wrfifo_full) chk("bp_no_wr", DW'(wr_req), DW'(0));
        if (rd_req) begin
            rd_cnt++;
            chk("rd_one_outstanding", DW'(pend), DW'(0));
            pend     = 1'b1;
            pend_dly = $urandom_range(0, 2);
        end
        rd_valid = 1'b0;
        rd_rresp = 2'd0;
        if (pend) begin
            if (pend_dly == 0) begin
                if (rd_q.size() > 0) begin
                    rd_data  = rd_q.pop_front();
                    rd_rresp = rs_q.pop_front();
                    rd_valid = 1'b1;
                end
                pend = 1'b0;
            end else begin
                pend_dly--;
            end
        end
        rdfifo_empty = (rd_q.size() == 0);
    endtask

    task automatic push_rd(input logic [DW-1:0] d, input logic [1:0] rs);
        rd_q.push_back(d);
        rs_q.push_back(rs);
    endtask

    task automatic begin_op(input int csz);
        rd_cnt       = 0;
        wr_cnt       = 0;
        comp_size    = CSW'(csz);
        rdfifo_empty = (rd_q.size() == 0);
        decomp_start = 1'b1;
    endtask

    task automatic run_op(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (decomp_done || decomp_err) break;
        end
        chk("op_finished", DW'(decomp_done | decomp_err), DW'(1));
    endtask

    task automatic end_op();
        decomp_start = 1'b0;
        tick();
        chk("end_done_low", DW'(decomp_done), DW'(0));
        chk("end_err_low", DW'(decomp_err), DW'(0));
        chk("end_code_zero", DW'(err_code), DW'(0));
        chk("end_busy_low", DW'(decomp_busy), DW'(0));
        tick();
    endtask

    task automatic check_success(input string tag, input int exp_rd);
        chk({tag, "_done"}, DW'(decomp_done), DW'(1));
        chk({tag, "_err"}, DW'(decomp_err), DW'(0));
        chk({tag, "_busy"}, DW'(decomp_busy), DW'(1));
        chk({tag, "_rd_cnt"}, DW'(rd_cnt), DW'(exp_rd));
        chk({tag, "_wr_cnt"}, DW'(wr_cnt), DW'(64));
        chk({tag, "_exp_left"}, DW'(exp_q.size()), DW'(0));
    endtask

    task automatic check_error(input string tag, input int code, input int exp_wr, input int exp_rd);
        chk({tag, "_err"}, DW'(decomp_err), DW'(1));
        chk({tag, "_done"}, DW'(decomp_done), DW'(0));
        chk({tag, "_code"}, DW'(err_code), DW'(code));
        chk({tag, "_wr_cnt"}, DW'(wr_cnt), DW'(exp_wr));
        chk({tag, "_rd_cnt"}, DW'(rd_cnt), DW'(exp_rd));
    endtask

    task automatic do_zero(input string tag);
        push_rd(DW'(8'h55), 2'd0);
        for (int k = 0; k < 64; k++) exp_q.push_back('0);
        begin_op(1);
        run_op(1000);
        check_success(tag, 1);
        end_op();
    endtask

    task automatic do_mixed(input string tag, input int base);
        push_rd(DW'(8'h81), 2'd0);
        for (int k = 0; k < 16; k++) exp_q.push_back('0);
        for (int k = 0; k < 32; k++) begin
            push_rd(pat(base + k), 2'd0);
            exp_q.push_back(pat(base + k));
        end
        push_rd(pat(base + 99), 2'd0);
        for (int k = 0; k < 16; k++) exp_q.push_back(pat(base + 99));
        begin_op(34);
        run_op(1000);
        check_success(tag, 34);
        end_op();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_req"}, DW'(rd_req), DW'(0));
        chk({tag, "_wr_req"}, DW'(wr_req), DW'(0));
        chk({tag, "_wr_data"}, wr_data, DW'(0));
        chk({tag, "_busy"}, DW'(decomp_busy), DW'(0));
        chk({tag, "_done"}, DW'(decomp_done), DW'(0));
        chk({tag, "_err"}, DW'(decomp_err), DW'(0));
        chk({tag, "_code"}, DW'(err_code), DW'(0));
    endtask

    initial begin
        n_total = 0; n_bad = 0; rd_cnt = 0; wr_cnt = 0;
        pend = 1'b0; pend_dly = 0; bp_check = 1'b0;
        rst_i = 1'b1; decomp_start = 1'b0; comp_size = '0; rdfifo_empty = 1'b1;
        rd_valid = 1'b0; rd_data = '0; rd_rresp = 2'd0; wrfifo_full = 1'b0;
        repeat (3) @(negedge clk_i);
        check_outputs_zero("reset");
        rst_i = 1'b0;
        tick();

        // all raw, incrementing payload
        push_rd(DW'(0), 2'd0);
        for (int k = 0; k < 64; k++) begin
            push_rd(pat(k), 2'd0);
            exp_q.push_back(pat(k));
        end
        begin_op(65);
        run_op(1000);
        check_success("all_raw", 65);
        end_op();

        do_zero("all_zero");
        do_mixed("mixed", 100);

        // size mismatch, then recovery
        push_rd(DW'(0), 2'd0);
        begin_op(64);
        run_op(200);
        check_error("size_mismatch", 2, 0, 1);
        end_op();
        do_zero("after_mismatch");

        // reserved mode
        push_rd(DW'(8'hC0), 2'd0);
        begin_op(33);
        run_op(200);
        check_error("reserved", 3, 0, 1);
        end_op();

        // bus error on payload line 5
        push_rd(DW'(0), 2'd0);
        for (int k = 0; k < 5; k++) begin
            push_rd(pat(300 + k), (k == 4) ? 2'd2 : 2'd0);
            if (k < 4) exp_q.push_back(pat(300 + k));
        end
        begin_op(65);
        run_op(500);
        check_error("rresp", 1, 4, 6);
        chk("rresp_exp_left", DW'(exp_q.size()), DW'(0));
        end_op();

        // backpressure during ZERO
        bp_check = 1'b1;
        push_rd(DW'(8'h55), 2'd0);
        for (int k = 0; k < 64; k++) exp_q.push_back('0);
        begin_op(1);
        for (int i = 0; i < 300 && wr_cnt < 20; i++) tick();
        wrfifo_full = 1'b1;
        repeat (10) tick();
        wrfifo_full = 1'b0;
        run_op(1000);
        check_success("backpressure", 1);
        end_op();
        bp_check = 1'b0;

        // reset mid-RAW
        push_rd(DW'(0), 2'd0);
        for (int k = 0; k < 64; k++) begin
            push_rd(pat(400 + k), 2'd0);
            exp_q.push_back(pat(400 + k));
        end
        begin_op(65);
        for (int i = 0; i < 500 && wr_cnt < 8; i++) tick();
        chk("pre_reset_busy", DW'(decomp_busy), DW'(1));
        rst_i = 1'b1;
        decomp_start = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        rd_q.delete(); rs_q.delete(); exp_q.delete();
        pend = 1'b0; rd_valid = 1'b0; rdfifo_empty = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        do_mixed("after_reset", 500);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hacd_decompressor_mc.md
Name: hacd_decompressor_mc

Overview:
- Parametrised zero/replicate-chunk decompressor for the HACD compression datapath.
- Reads a compressed page from the read FIFO: one metadata line, then payload lines.
- Expands NUM_CHUNKS chunks of LINES_PER_CHUNK lines each into the write FIFO.
- Per-chunk 2-bit mode (raw, zero, replicate), compressed-size cross-check, and error reporting with recovery; the previous decompressor had only zero/raw modes and a lock-up on error.

Parameters:
- DATA_WIDTH, 512, width of read and write data lines.
- NUM_CHUNKS, 4, chunks per page.
- LINES_PER_CHUNK, 16, lines per expanded chunk (power of two, at least 2).
- CSZ_W, 14, width of comp_size.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- decomp_start  in  1  level request; held until done or error is observed.
- comp_size  in  CSZ_W  compressed length in lines, including the metadata line.
- rdfifo_empty  in  1  read FIFO empty.
- rd_req  out  1  one-cycle read pop request.
- rd_valid  in  1  read data valid; at least 1 cycle after rd_req.
- rd_data  in  DATA_WIDTH  read line.
- rd_rresp  in  2  read response; nonzero means bus error.
- wrfifo_full  in  1  write FIFO almost-full; asserted with 2 or fewer free entries.
- wr_req  out  1  one-cycle write push.
- wr_data  out  DATA_WIDTH  write line.
- decomp_busy  out  1  high in any state other than IDLE.
- decomp_done  out  1  completion, held while decomp_start is high.
- decomp_err  out  1  error, held while decomp_start is high.
- err_code  out  2  1 = rresp error, 2 = size mismatch, 3 = reserved mode; 0 otherwise.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters cleared. Reset during an operation aborts it immediately.
- All outputs are registered.
- Metadata format: chunk i mode is at rd_data[2i+1:2i].
  - 00: raw, LINES_PER_CHUNK payload lines.
  - 01: zero, no payload.
  - 10: replicate, 1 payload line written LINES_PER_CHUNK times.
  - 11: reserved.
- Read rule:
  - At most one outstanding read.
  - rd_req is issued only when rdfifo_empty is low and nothing is outstanding.
  - In raw mode, rd_req additionally requires wrfifo_full low.
  - The outstanding flag clears on rd_valid.
- Write rule: a fill step occurs in a cycle with wrfifo_full low. wr_req/wr_data are asserted the next cycle for exactly one cycle.
- FSM states:
  - IDLE: on decomp_start with rdfifo_empty low, go to META.
  - META: one read. On rd_valid:
    - rresp nonzero: ERROR, code 1.
    - else any chunk mode 11: ERROR, code 3.
    - else compute expected = 1 + (raw count x LINES_PER_CHUNK) + (replicate count). If expected differs from comp_size, the width-extended compare fails: ERROR, code 2.
    - else latch modes, chunk index = 0, go to SEL.
  - SEL: if chunk index = NUM_CHUNKS, go to DONE. Otherwise clear the line count and dispatch on the mode of the current chunk to ZERO, RAW or REP_LD.
  - ZERO: write 0 per fill step. After LINES_PER_CHUNK writes, increment chunk index and go to SEL.
  - RAW: on rd_valid with rresp 0, write rd_data and increment the line count. On nonzero rresp, no write, go to ERROR with code 1. After LINES_PER_CHUNK lines, go to SEL.
  - REP_LD: one read, latch the line (rresp check as in RAW), go to REP_FILL.
  - REP_FILL: write the latched line LINES_PER_CHUNK times, then go to SEL.
  - DONE: decomp_done = 1 while decomp_start is high. When decomp_start falls, go to IDLE and decomp_done falls the next cycle.
  - ERROR: decomp_err = 1 and err_code held while decomp_start is high. When decomp_start falls, go to IDLE and clear both.
- Chunks are processed in ascending index order.
- Total writes on success: exactly NUM_CHUNKS x LINES_PER_CHUNK.
- Total reads on success: exactly comp_size.
- decomp_start deasserting mid-operation is ignored until DONE or ERROR.
- An rd_valid arriving while the write path is stalled is still consumed. The almost-full slack guarantees room for it.
- The line counter is $clog2(LINES_PER_CHUNK)+1 bits wide. The chunk index is $clog2(NUM_CHUNKS)+1 bits wide.

Test Plan (defaults: 4 chunks, 16 lines each):
- All raw: meta 0x00, comp_size 65, incrementing payload → 64 writes matching the payload in order; 65 rd_req; done.
- All zero: meta 0x55, comp_size 1 → 1 rd_req, 64 zero writes, done. Deassert start → done falls, busy falls.
- Mixed: meta 0x81 (c0 zero, c1 raw, c2 raw, c3 replicate), comp_size 34 → 16 zeros, 32 payload lines, the 34th line written 16 times.
- Size mismatch: meta 0x00, comp_size 64 → err_code 2, decomp_err high, 0 writes, 1 rd_req. Drop start → IDLE, a new start succeeds.
- Reserved mode: meta 0xC0, comp_size 33 → err_code 3, 0 writes.
- rresp error: all raw, rresp = 2 on payload line 5 → 4 writes, err_code 2'b01.
- Backpressure: wrfifo_full held for 10 cycles during ZERO → no wr_req in those cycles; total of 64 writes preserved.
- Reset: rst_i pulsed mid-RAW → all outputs 0 immediately; next start completes normally.
